// File: rtl/stw_wt_ctrl.sv
// stw_wt_ctrl: button-driven control FSM for the stopwatch/watch unit.
// Turns single-cycle button pulses into the view select, stopwatch run/clear
// controls and watch time-set increment pulses. A 100 Hz tick drives the
// edit-field blink and the edit-mode timeout. All outputs are registered.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset
//   i_tick       1-cycle pulse at 100 Hz
//   i_btn_mode   toggle stopwatch/watch view
//   i_btn_run    stopwatch run/stop toggle
//   i_btn_clear  stopwatch clear (only while stopped)
//   i_btn_set    watch edit-field advance
//   i_btn_up     increment the selected watch field
//   o_sw_mode    view select, 0 = stopwatch, 1 = watch
//   o_run        stopwatch count enable (level)
//   o_clear      1-cycle stopwatch clear pulse
//   o_set_field  0 none, 1 hour, 2 min, 3 sec
//   o_inc_hour   1-cycle hour increment pulse
//   o_inc_min    1-cycle minute increment pulse
//   o_inc_sec    1-cycle second increment pulse
//   o_blink      display enable for the edited field, 1 when not editing
module stw_wt_ctrl #(
  parameter int unsigned BLINK_TICKS   = 50,
  parameter int unsigned TIMEOUT_TICKS = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_tick,
  input  logic       i_btn_mode,
  input  logic       i_btn_run,
  input  logic       i_btn_clear,
  input  logic       i_btn_set,
  input  logic       i_btn_up,
  output logic       o_sw_mode,
  output logic       o_run,
  output logic       o_clear,
  output logic [1:0] o_set_field,
  output logic       o_inc_hour,
  output logic       o_inc_min,
  output logic       o_inc_sec,
  output logic       o_blink
);

  localparam int unsigned BLINK_W = $clog2(BLINK_TICKS + 1);
  localparam int unsigned TO_W    = $clog2(TIMEOUT_TICKS + 1);

  typedef enum logic [2:0] {
    ST_STW      = 3'd0,
    ST_WT_NORM  = 3'd1,
    ST_WT_SET_H = 3'd2,
    ST_WT_SET_M = 3'd3,
    ST_WT_SET_S = 3'd4
  } state_t;

  state_t             r_state;
  logic               r_sw_mode;
  logic               r_run;
  logic               r_clear;
  logic [1:0]         r_set_field;
  logic               r_inc_hour;
  logic               r_inc_min;
  logic               r_inc_sec;
  logic               r_blink;
  logic [BLINK_W-1:0] r_blink_cnt;
  logic [TO_W-1:0]    r_to_cnt;

  state_t             w_state_nxt;
  logic               w_run_nxt;
  logic               w_clear_nxt;
  logic               w_inc_hour_nxt;
  logic               w_inc_min_nxt;
  logic               w_inc_sec_nxt;
  logic               w_blink_nxt;
  logic [1:0]         w_field_nxt;
  logic [BLINK_W-1:0] w_blink_cnt_nxt;
  logic [BLINK_W-1:0] w_blink_base;
  logic               w_blink_lvl_base;
  logic [TO_W-1:0]    w_to_cnt_nxt;
  logic [TO_W-1:0]    w_to_base;
  logic               w_to_clr;
  logic               w_entry;

  // One button acts per cycle; the highest-priority pulse wins even when the
  // current state ignores it, and lower pulses that cycle are dropped.
  logic w_sel_mode, w_sel_set, w_sel_run, w_sel_clear, w_sel_up;
  assign w_sel_mode  = i_btn_mode;
  assign w_sel_set   = i_btn_set   & ~i_btn_mode;
  assign w_sel_run   = i_btn_run   & ~i_btn_mode & ~i_btn_set;
  assign w_sel_clear = i_btn_clear & ~i_btn_mode & ~i_btn_set & ~i_btn_run;
  assign w_sel_up    = i_btn_up    & ~i_btn_mode & ~i_btn_set & ~i_btn_run & ~i_btn_clear;

  function automatic logic f_is_set(input state_t s);
    return (s == ST_WT_SET_H) || (s == ST_WT_SET_M) || (s == ST_WT_SET_S);
  endfunction

  // Next-state, next-output and counter logic.
  always_comb begin
    w_state_nxt      = r_state;
    w_run_nxt        = r_run;
    w_clear_nxt      = 1'b0;
    w_inc_hour_nxt   = 1'b0;
    w_inc_min_nxt    = 1'b0;
    w_inc_sec_nxt    = 1'b0;
    w_to_clr         = 1'b0;
    w_entry          = 1'b0;
    w_to_base        = r_to_cnt;
    w_blink_base     = r_blink_cnt;
    w_blink_lvl_base = r_blink;
    w_to_cnt_nxt     = '0;
    w_blink_cnt_nxt  = '0;
    w_blink_nxt      = 1'b1;
    w_field_nxt      = 2'd0;

    unique case (r_state)
      ST_STW: begin
        if (w_sel_mode) begin
          w_state_nxt = ST_WT_NORM;
        end else if (w_sel_run) begin
          w_run_nxt = ~r_run;
        end else if (w_sel_clear && !r_run) begin
          w_clear_nxt = 1'b1;
        end
      end
      ST_WT_NORM: begin
        if (w_sel_mode) begin
          w_state_nxt = ST_STW;
        end else if (w_sel_set) begin
          w_state_nxt = ST_WT_SET_H;
        end
      end
      ST_WT_SET_H: begin
        if (w_sel_set) begin
          w_state_nxt = ST_WT_SET_M;
          w_to_clr    = 1'b1;
        end else if (w_sel_up) begin
          w_inc_hour_nxt = 1'b1;
          w_to_clr       = 1'b1;
        end
      end
      ST_WT_SET_M: begin
        if (w_sel_set) begin
          w_state_nxt = ST_WT_SET_S;
          w_to_clr    = 1'b1;
        end else if (w_sel_up) begin
          w_inc_min_nxt = 1'b1;
          w_to_clr      = 1'b1;
        end
      end
      ST_WT_SET_S: begin
        if (w_sel_set) begin
          w_state_nxt = ST_WT_NORM;
          w_to_clr    = 1'b1;
        end else if (w_sel_up) begin
          w_inc_sec_nxt = 1'b1;
          w_to_clr      = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_STW;
      end
    endcase

    // Entering any set state restarts both counters and shows the field.
    w_entry = f_is_set(w_state_nxt) && (w_state_nxt != r_state);
    if (w_entry || w_to_clr) begin
      w_to_base = '0;
    end
    if (w_entry) begin
      w_blink_base     = '0;
      w_blink_lvl_base = 1'b1;
    end

    // Idle timeout: the tick that reaches the limit leaves edit mode.
    if (f_is_set(w_state_nxt) && i_tick &&
        (TO_W'(w_to_base + TO_W'(1)) == TO_W'(TIMEOUT_TICKS))) begin
      w_state_nxt = ST_WT_NORM;
    end

    if (f_is_set(w_state_nxt)) begin
      w_to_cnt_nxt    = w_to_base;
      w_blink_cnt_nxt = w_blink_base;
      w_blink_nxt     = w_blink_lvl_base;
      if (i_tick) begin
        w_to_cnt_nxt = TO_W'(w_to_base + TO_W'(1));
        if (BLINK_W'(w_blink_base + BLINK_W'(1)) == BLINK_W'(BLINK_TICKS)) begin
          w_blink_cnt_nxt = '0;
          w_blink_nxt     = ~w_blink_lvl_base;
        end else begin
          w_blink_cnt_nxt = BLINK_W'(w_blink_base + BLINK_W'(1));
        end
      end
    end

    unique case (w_state_nxt)
      ST_WT_SET_H: w_field_nxt = 2'd1;
      ST_WT_SET_M: w_field_nxt = 2'd2;
      ST_WT_SET_S: w_field_nxt = 2'd3;
      default:     w_field_nxt = 2'd0;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_STW;
      r_sw_mode   <= 1'b0;
      r_run       <= 1'b0;
      r_clear     <= 1'b0;
      r_set_field <= 2'd0;
      r_inc_hour  <= 1'b0;
      r_inc_min   <= 1'b0;
      r_inc_sec   <= 1'b0;
      r_blink     <= 1'b1;
      r_blink_cnt <= '0;
      r_to_cnt    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_sw_mode   <= (w_state_nxt != ST_STW);
      r_run       <= w_run_nxt;
      r_clear     <= w_clear_nxt;
      r_set_field <= w_field_nxt;
      r_inc_hour  <= w_inc_hour_nxt;
      r_inc_min   <= w_inc_min_nxt;
      r_inc_sec   <= w_inc_sec_nxt;
      r_blink     <= w_blink_nxt;
      r_blink_cnt <= w_blink_cnt_nxt;
      r_to_cnt    <= w_to_cnt_nxt;
    end
  end

  assign o_sw_mode   = r_sw_mode;
  assign o_run       = r_run;
  assign o_clear     = r_clear;
  assign o_set_field = r_set_field;
  assign o_inc_hour  = r_inc_hour;
  assign o_inc_min   = r_inc_min;
  assign o_inc_sec   = r_inc_sec;
  assign o_blink     = r_blink;

endmodule
